fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Instruction-fetch stage of the pipelined MIPS datapath, directly upstream of the IF/ID latch. Owns the program counter, drives the instruction-cache request, and presents each fetched instruction with its next-PC to IF/ID together with a one-cycle valid (the latch's ihit) and a flush strobe (the latch's doflush). Handles branch/jump redirects, including redirects that arrive while an icache miss is outstanding, plus hazard stalls and a sticky halt.

## Interface
- PC_INIT, 32'h0000_0000, PC value after reset
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  icache has a valid instruction for imemaddr this cycle
- imemload  in  32  instruction word from icache, valid when ihit=1
- redirect_en  in  1  branch/jump resolved taken this cycle
- redirect_pc  in  32  redirect target
- stall  in  1  hazard unit holds fetch (IF/ID pause)
- halt  in  1  halt instruction committed downstream
- imemREN  out  1  icache read enable
- imemaddr  out  32  icache address (= PC register)
- ifid_valid  out  1  deliver instruction to IF/ID this cycle
- ifid_npc  out  32  PC+4 of the delivered instruction
- ifid_imemload  out  32  delivered instruction word
- ifid_flush  out  1  flush IF/ID this cycle
- halted  out  1  fetch permanently stopped
- fetch_count  out  32  number of instructions delivered since reset

## Operation
- Registers: pc (32), state {FETCH, SQUASH, HALT}, pend_pc (32), fetch_count (32).
- Reset (nRST=0): pc=PC_INIT, state=FETCH, pend_pc=0, fetch_count=0. Outputs during reset: imemREN=0, imemaddr=PC_INIT, ifid_valid=0, ifid_flush=0, halted=0.
- imemaddr = pc always. ifid_npc = pc+4 (mod 2^32). ifid_imemload = imemload.
- Icache rule: while imemREN=1 and ihit=0, imemaddr must not change.
- Redirect targets are word-aligned by forcing bits [1:0] to 00.
- FETCH (imemREN=1), priority order:
  - halt=1: state→HALT; ifid_valid=0.
  - redirect_en=1 and ihit=1: pc←target; ifid_flush=1; ifid_valid=0. The fetched word is discarded.
  - redirect_en=1 and ihit=0: pend_pc←target; state→SQUASH; ifid_flush=1; pc unchanged.
  - ihit=1 and stall=0: ifid_valid=1; pc←pc+4; fetch_count+1.
  - ihit=1 and stall=1: ifid_valid=0; pc held, so the same word is refetched.
  - ihit=0: hold.
- SQUASH (imemREN=1, imemaddr=old pc):
  - halt=1: state→HALT.
  - redirect_en=1: pend_pc←new target (latest wins); ifid_flush=1.
  - ihit=1: word discarded (ifid_valid=0); pc←pend_pc (or the same-cycle new target); state→FETCH.
  - stall is ignored in SQUASH.
- HALT: imemREN=0, ifid_valid=0, ifid_flush=0, halted=1, pc frozen. Sticky until nRST.
- ifid_valid is never 1 in a cycle where ifid_flush=1 or halted=1.

## Timing
- ifid_valid, ifid_flush, imemREN and imemaddr are combinational from the current state/inputs and pc. pc, state, pend_pc and fetch_count update on the rising CLK.
- Hit latency: imemaddr presented in cycle N, ihit in N gives ifid_valid in N, and pc+4 appears on imemaddr in N+1. Back-to-back hits give one instruction per cycle.
- Same-cycle redirect with hit: the target appears on imemaddr the next cycle (one bubble).
- Redirect during a miss: the old request completes and is discarded. The target appears on imemaddr the cycle after that ihit.
- Halt takes effect the same cycle: no delivery in the halt cycle. halted rises after the edge.
- Async reset mid-miss or mid-SQUASH: all state is cleared immediately, and the pending target is lost.
- pc at 32'hFFFF_FFFC with a hit wraps pc to 0, and ifid_npc=0.
- fetch_count wraps mod 2^32.

## Test plan
- Reset, then ihit=1 constantly with stall=0 for 4 cycles -> imemaddr 0,4,8,C; ifid_valid=1 each cycle; ifid_npc 4,8,C,10; fetch_count=4.
- ihit=1, stall=1 for 2 cycles at pc=8 -> imemaddr stays 8; ifid_valid=0; fetch_count unchanged; after release, valid with ifid_npc=C.
- At pc=10, redirect_en=1 with redirect_pc=0x40 and ihit=1 -> ifid_flush=1, ifid_valid=0 that cycle; next cycle imemaddr=0x40.
- At pc=20 with ihit=0, redirect to 0x80, then to 0x90 two cycles later, then ihit=1 after 5 cycles -> imemaddr holds 20 throughout; ifid_flush pulses on both redirect cycles; the hit is discarded; then imemaddr=0x90.
- halt=1 together with ihit=1 and redirect_en=1 -> ifid_valid=0; next cycle halted=1, imemREN=0, pc frozen; halted stays 1 until nRST.
- With PC_INIT=32'hFFFF_FFFC, ihit=1 -> ifid_npc=0 and next imemaddr=0. Redirect_pc=0x47 -> imemaddr=0x44.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues icache reads and hands hits to IF/ID.
// Redirects that land during an outstanding miss are parked in pend_pc until the miss completes.
module fetch_pc_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        ifid_valid,
  output logic [31:0] ifid_npc,
  output logic [31:0] ifid_imemload,
  output logic        ifid_flush,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {FETCH, SQUASH, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pend_pc, pend_pc_next;
  logic [31:0] count, count_next;
  logic [31:0] target;
  logic        req, deliver, flush;

  assign target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= FETCH;
      pc      <= PC_INIT;
      pend_pc <= 32'h0;
      count   <= 32'h0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pend_pc <= pend_pc_next;
      count   <= count_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pend_pc_next = pend_pc;
    count_next   = count;
    req          = 1'b0;
    deliver      = 1'b0;
    flush        = 1'b0;
    case (state)
      FETCH: begin
        req = 1'b1;
        if (halt) begin
          state_next = HALT;
        end else if (redirect_en) begin
          flush = 1'b1;
          if (ihit) begin
            pc_next = target;
          end else begin
            // The miss must complete at the old address before the PC can move.
            pend_pc_next = target;
            state_next   = SQUASH;
          end
        end else if (ihit && !stall) begin
          deliver    = 1'b1;
          pc_next    = pc + 32'd4;
          count_next = count + 32'd1;
        end
      end
      SQUASH: begin
        req = 1'b1;
        if (halt) begin
          state_next = HALT;
        end else begin
          if (redirect_en) begin
            flush        = 1'b1;
            pend_pc_next = target;
          end
          if (ihit) begin
            pc_next    = redirect_en ? target : pend_pc;
            state_next = FETCH;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Reset forces the request and IF/ID strobes low even though state already reads FETCH.
  assign imemREN       = req & nRST;
  assign ifid_valid    = deliver & nRST;
  assign ifid_flush    = flush & nRST;
  assign imemaddr      = pc;
  assign ifid_npc      = pc + 32'd4;
  assign ifid_imemload = imemload;
  assign halted        = (state == HALT);
  assign fetch_count   = count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomised + directed bench for fetch_pc_unit; two instances with different reset PCs.
// Expected outputs are queued by the driver and compared by an independent monitor.
module tb_fetch_pc_unit;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] npc;
    logic [31:0] load;
    logic        flush;
    logic        halted;
    logic [31:0] count;
  } exp_t;

  // Reference state: a PC, an optional parked redirect, a halt latch and a delivery tally.
  typedef struct {
    logic [31:0] pc;
    bit          has_parked;
    logic [31:0] parked;
    bit          stopped;
    logic [31:0] delivered;
  } mdl_t;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'h0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;

  logic        ren   [2];
  logic [31:0] addr  [2];
  logic        valid [2];
  logic [31:0] npc   [2];
  logic [31:0] load  [2];
  logic        flush [2];
  logic        hlt   [2];
  logic [31:0] cnt   [2];

  localparam logic [31:0] INIT0 = 32'h0000_0000;
  localparam logic [31:0] INIT1 = 32'hFFFF_FFFC;

  fetch_pc_unit #(.PC_INIT(INIT0)) dut0 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .stall(stall), .halt(halt),
    .imemREN(ren[0]), .imemaddr(addr[0]), .ifid_valid(valid[0]), .ifid_npc(npc[0]),
    .ifid_imemload(load[0]), .ifid_flush(flush[0]), .halted(hlt[0]), .fetch_count(cnt[0])
  );

  fetch_pc_unit #(.PC_INIT(INIT1)) dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .stall(stall), .halt(halt),
    .imemREN(ren[1]), .imemaddr(addr[1]), .ifid_valid(valid[1]), .ifid_npc(npc[1]),
    .ifid_imemload(load[1]), .ifid_flush(flush[1]), .halted(hlt[1]), .fetch_count(cnt[1])
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  mdl_t m  [2];
  mdl_t mn [2];

  function automatic mdl_t fresh(input int i);
    mdl_t r;
    r.pc         = (i == 0) ? INIT0 : INIT1;
    r.has_parked = 0;
    r.parked     = 32'h0;
    r.stopped    = 0;
    r.delivered  = 32'h0;
    return r;
  endfunction

  // Expected visible behaviour this cycle plus the state after the coming edge.
  function automatic void predict(input mdl_t cur, input bit in_rst, output exp_t e, output mdl_t nxt);
    logic [31:0] tgt;
    tgt      = redirect_pc & 32'hFFFF_FFFC;
    nxt      = cur;
    e.addr   = cur.pc;
    e.npc    = cur.pc + 32'd4;
    e.load   = imemload;
    e.halted = cur.stopped;
    e.count  = cur.delivered;
    e.ren    = 0;
    e.valid  = 0;
    e.flush  = 0;
    if (in_rst || cur.stopped) return;
    e.ren = 1;
    if (halt) begin
      nxt.stopped = 1;
    end else if (cur.has_parked) begin
      if (redirect_en) begin
        e.flush    = 1;
        nxt.parked = tgt;
      end
      if (ihit) begin
        nxt.pc         = redirect_en ? tgt : cur.parked;
        nxt.has_parked = 0;
      end
    end else if (redirect_en) begin
      e.flush = 1;
      if (ihit) nxt.pc = tgt;
      else begin
        nxt.has_parked = 1;
        nxt.parked     = tgt;
      end
    end else if (ihit && !stall) begin
      e.valid       = 1;
      nxt.pc        = cur.pc + 32'd4;
      nxt.delivered = cur.delivered + 32'd1;
    end
  endfunction

  task automatic cyc(input bit r, input bit h, input bit st, input bit re,
                     input logic [31:0] rpc, input bit hl);
    exp_t e;
    @(posedge CLK);
    if (nRST) begin
      m[0] = mn[0];
      m[1] = mn[1];
    end
    #1;
    nRST        = !r;
    ihit        = h;
    stall       = st;
    redirect_en = re;
    redirect_pc = rpc;
    halt        = hl;
    imemload    = $urandom;
    if (r) begin
      m[0] = fresh(0);
      m[1] = fresh(1);
    end
    predict(m[0], r, e, mn[0]);
    exp_q0.push_back(e);
    predict(m[1], r, e, mn[1]);
    exp_q1.push_back(e);
  endtask

  task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL dut%0d %s: got %h expected %h at %0t", inst, name, act, want, $time);
    end
  endtask

  task automatic compare(input int i, input exp_t e);
    chk(i, "imemREN", {31'b0, ren[i]}, {31'b0, e.ren});
    chk(i, "imemaddr", addr[i], e.addr);
    chk(i, "ifid_valid", {31'b0, valid[i]}, {31'b0, e.valid});
    chk(i, "ifid_npc", npc[i], e.npc);
    chk(i, "ifid_imemload", load[i], e.load);
    chk(i, "ifid_flush", {31'b0, flush[i]}, {31'b0, e.flush});
    chk(i, "halted", {31'b0, hlt[i]}, {31'b0, e.halted});
    chk(i, "fetch_count", cnt[i], e.count);
    chk(i, "valid_exclusive", {31'b0, valid[i] & (flush[i] | hlt[i])}, 32'h0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (exp_q0.size() != 0) compare(0, exp_q0.pop_front());
      if (exp_q1.size() != 0) compare(1, exp_q1.pop_front());
    end
  end

  initial begin : driver
    int halted_for;
    bit r, h, st, re, hl;
    logic [31:0] rpc;
    m[0] = fresh(0);  m[1] = fresh(1);
    mn[0] = fresh(0); mn[1] = fresh(1);

    // Reset, then four back-to-back hits.
    cyc(1, 0, 0, 0, 32'h0, 0);
    cyc(1, 1, 0, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 32'h0, 0);
    // Stall with hit for two cycles, then release.
    cyc(1, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 0, 32'h0, 0);
    cyc(0, 1, 1, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 0);
    // Redirect with a same-cycle hit.
    cyc(0, 1, 0, 1, 32'h40, 0);
    cyc(0, 1, 0, 0, 32'h0, 0);
    // Two redirects during a miss; latest target wins after the hit.
    cyc(0, 0, 0, 1, 32'h80, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 1, 32'h90, 0);
    cyc(0, 0, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 0);
    // Misaligned target, then halt with hit and redirect; halt stays sticky.
    cyc(0, 1, 0, 1, 32'h47, 0);
    cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 1, 32'h100, 1);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 1, 32'h200, 0);
    // Reset landing in the middle of a parked redirect.
    cyc(1, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 1, 32'h300, 0);
    cyc(1, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 0);

    halted_for = 0;
    for (int k = 0; k < 3000; k++) begin
      h   = ($urandom_range(0, 99) < 60);
      st  = ($urandom_range(0, 99) < 20);
      re  = ($urandom_range(0, 99) < 15);
      hl  = ($urandom_range(0, 199) == 0);
      rpc = $urandom;
      halted_for = m[0].stopped ? halted_for + 1 : 0;
      r   = ($urandom_range(0, 99) == 0) || (halted_for > 6);
      cyc(r, h, st, re, rpc, hl);
    end

    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
